rr_exe_skid_stage: RTL and testbench

//  Parametrised RR->EXE pipeline stage replacing the fixed lock-based latch: valid/ready handshake with a
//  2-entry skid buffer, so upstream never sees a combinational stall path. Carries PC, instruction,

---
 rtl/rr_exe_skid_stage_pkg.sv | 25 ++
 rtl/rr_exe_skid_stage_entry.sv | 91 +++++++++
 rtl/rr_exe_skid_stage.sv | 241 ++++++++++++++++++++++++
 tb/tb_rr_exe_skid_stage.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/rr_exe_skid_stage_pkg.sv
// Shared definitions for the RR->EXE skid stage: state encodings,
// the cleared exception-cause value and a state-to-occupancy helper.
package rr_exe_skid_stage_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } stage_state_e;

    localparam logic [63:0] XCPT_CAUSE_ZERO = 64'd0;

    // Number of entries held in a given stage state.
    function automatic logic [1:0] state_occupancy(input stage_state_e st);
        logic [1:0] occ;
        case (st)
            ST_EMPTY: occ = 2'd0;
            ST_ONE:   occ = 2'd1;
            ST_TWO:   occ = 2'd2;
            default:  occ = 2'd0;
        endcase
        return occ;
    endfunction

endpackage

// File: rtl/rr_exe_skid_stage_entry.sv
// One pipeline entry: payload registers, valid flag and a pending flag for
// operands that arrive one cycle after the instruction. Clear beats load,
// load beats late capture.
module rr_exe_skid_stage_entry
    import rr_exe_skid_stage_pkg::*;
#(
    parameter int ADDR_W  = 40,
    parameter int INST_W  = 32,
    parameter int CTRL_W  = 16,
    parameter int CAUSE_W = 64,
    parameter int SRC_W   = 128
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               clr_i,
    input  logic               ld_i,
    input  logic               ld_pend_i,
    input  logic [ADDR_W-1:0]  ld_pc_i,
    input  logic [INST_W-1:0]  ld_inst_i,
    input  logic [CTRL_W-1:0]  ld_ctrl_i,
    input  logic               ld_xcpt_i,
    input  logic [CAUSE_W-1:0] ld_cause_i,
    input  logic [SRC_W-1:0]   ld_data_i,
    input  logic               cap_i,
    input  logic [SRC_W-1:0]   cap_data_i,
    output logic               valid_o,
    output logic               pend_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic [INST_W-1:0]  inst_o,
    output logic [CTRL_W-1:0]  ctrl_o,
    output logic               xcpt_o,
    output logic [CAUSE_W-1:0] cause_o,
    output logic [SRC_W-1:0]   data_o
);

    logic               valid_r;
    logic               pend_r;
    logic [ADDR_W-1:0]  pc_r;
    logic [INST_W-1:0]  inst_r;
    logic [CTRL_W-1:0]  ctrl_r;
    logic               xcpt_r;
    logic [CAUSE_W-1:0] cause_r;
    logic [SRC_W-1:0]   data_r;

    // Entry storage: zeroed when invalid so EXE sees a clean bubble.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid_r <= 1'b0;
            pend_r  <= 1'b0;
            pc_r    <= '0;
            inst_r  <= '0;
            ctrl_r  <= '0;
            xcpt_r  <= 1'b0;
            cause_r <= CAUSE_W'(XCPT_CAUSE_ZERO);
            data_r  <= '0;
        end else if (clr_i) begin
            valid_r <= 1'b0;
            pend_r  <= 1'b0;
            pc_r    <= '0;
            inst_r  <= '0;
            ctrl_r  <= '0;
            xcpt_r  <= 1'b0;
            cause_r <= CAUSE_W'(XCPT_CAUSE_ZERO);
            data_r  <= '0;
        end else if (ld_i) begin
            valid_r <= 1'b1;
            pend_r  <= ld_pend_i;
            pc_r    <= ld_pc_i;
            inst_r  <= ld_inst_i;
            ctrl_r  <= ld_ctrl_i;
            xcpt_r  <= ld_xcpt_i;
            cause_r <= ld_cause_i;
            data_r  <= ld_data_i;
        end else if (cap_i) begin
            pend_r  <= 1'b0;
            data_r  <= cap_data_i;
        end else begin
            pend_r  <= pend_r;
        end
    end

    assign valid_o = valid_r;
    assign pend_o  = pend_r;
    assign pc_o    = pc_r;
    assign inst_o  = inst_r;
    assign ctrl_o  = ctrl_r;
    assign xcpt_o  = xcpt_r;
    assign cause_o = cause_r;
    assign data_o  = data_r;

endmodule

// File: rtl/rr_exe_skid_stage.sv
// RR->EXE pipeline stage with a 2-entry skid buffer (head + skid). Upstream
// ready is registered, so no combinational stall path reaches RR. Late
// register-file operands are captured the cycle after the beat and bypassed
// to EXE while the head is still waiting for them.
module rr_exe_skid_stage
    import rr_exe_skid_stage_pkg::*;
#(
    parameter int ADDR_W    = 40,
    parameter int INST_W    = 32,
    parameter int CTRL_W    = 16,
    parameter int DATA_W    = 64,
    parameter int CAUSE_W   = 64,
    parameter int NUM_SRC   = 2,
    parameter int LATE_OPND = 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      flush_p1_i,
    input  logic                      flush_p2_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [ADDR_W-1:0]         in_pc_i,
    input  logic [INST_W-1:0]         in_inst_i,
    input  logic [CTRL_W-1:0]         in_ctrl_i,
    input  logic                      in_xcpt_i,
    input  logic [CAUSE_W-1:0]        in_xcpt_cause_i,
    input  logic [NUM_SRC*DATA_W-1:0] src_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [ADDR_W-1:0]         out_pc_o,
    output logic [INST_W-1:0]         out_inst_o,
    output logic [CTRL_W-1:0]         out_ctrl_o,
    output logic                      out_xcpt_o,
    output logic [CAUSE_W-1:0]        out_xcpt_cause_o,
    output logic [NUM_SRC*DATA_W-1:0] out_src_data_o,
    output logic [1:0]                occupancy_o
);

    localparam int   SRC_W  = NUM_SRC * DATA_W;
    localparam logic LATE_L = (LATE_OPND != 0);

    stage_state_e state_r, state_nxt_s;
    logic         in_ready_r;
    logic [1:0]   occ_r;

    logic acc_s, pop_s;
    logic head_clr_s, head_ld_s, head_from_skid_s, head_cap_s;
    logic skid_clr_s, skid_ld_s, skid_cap_s;

    logic               head_valid_s, head_pend_s, head_xcpt_s;
    logic [ADDR_W-1:0]  head_pc_s;
    logic [INST_W-1:0]  head_inst_s;
    logic [CTRL_W-1:0]  head_ctrl_s;
    logic [CAUSE_W-1:0] head_cause_s;
    logic [SRC_W-1:0]   head_data_s;

    logic               skid_valid_s, skid_pend_s, skid_xcpt_s;
    logic [ADDR_W-1:0]  skid_pc_s;
    logic [INST_W-1:0]  skid_inst_s;
    logic [CTRL_W-1:0]  skid_ctrl_s;
    logic [CAUSE_W-1:0] skid_cause_s;
    logic [SRC_W-1:0]   skid_data_s;

    // Incoming beat as it will be stored: exceptions carry no control bits,
    // late operands are filled in by the following cycle's capture.
    logic [CTRL_W-1:0]  inc_ctrl_s;
    logic [SRC_W-1:0]   inc_data_s;
    logic               inc_pend_s;

    // Head load source: incoming beat, or the skid entry moving forward.
    logic [ADDR_W-1:0]  hld_pc_s;
    logic [INST_W-1:0]  hld_inst_s;
    logic [CTRL_W-1:0]  hld_ctrl_s;
    logic               hld_xcpt_s;
    logic [CAUSE_W-1:0] hld_cause_s;
    logic [SRC_W-1:0]   hld_data_s;
    logic               hld_pend_s;

    assign acc_s = in_valid_i & in_ready_r;
    assign pop_s = head_valid_s & out_ready_i;

    assign inc_ctrl_s = in_xcpt_i ? {CTRL_W{1'b0}} : in_ctrl_i;
    assign inc_data_s = LATE_L ? {SRC_W{1'b0}} : src_data_i;
    assign inc_pend_s = LATE_L;

    assign hld_pc_s    = head_from_skid_s ? skid_pc_s    : in_pc_i;
    assign hld_inst_s  = head_from_skid_s ? skid_inst_s  : in_inst_i;
    assign hld_ctrl_s  = head_from_skid_s ? skid_ctrl_s  : inc_ctrl_s;
    assign hld_xcpt_s  = head_from_skid_s ? skid_xcpt_s  : in_xcpt_i;
    assign hld_cause_s = head_from_skid_s ? skid_cause_s : in_xcpt_cause_i;
    // A skid entry still waiting for operands takes them on its way to head.
    assign hld_data_s  = head_from_skid_s ? (skid_pend_s ? src_data_i : skid_data_s) : inc_data_s;
    assign hld_pend_s  = head_from_skid_s ? 1'b0 : inc_pend_s;

    // Next-state and entry control: p1 flush, then p2 flush, then handshake.
    always_comb begin
        state_nxt_s      = state_r;
        head_clr_s       = 1'b0;
        head_ld_s        = 1'b0;
        head_from_skid_s = 1'b0;
        skid_clr_s       = 1'b0;
        skid_ld_s        = 1'b0;
        head_cap_s       = head_pend_s;
        skid_cap_s       = skid_pend_s;
        if (flush_p1_i) begin
            state_nxt_s = ST_EMPTY;
            head_clr_s  = 1'b1;
            skid_clr_s  = 1'b1;
        end else if (flush_p2_i) begin
            skid_clr_s = 1'b1;
            if (head_valid_s && !out_ready_i) begin
                state_nxt_s = ST_ONE;
            end else begin
                state_nxt_s = ST_EMPTY;
                head_clr_s  = 1'b1;
            end
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (acc_s) begin
                        head_ld_s   = 1'b1;
                        state_nxt_s = ST_ONE;
                    end else begin
                        state_nxt_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (acc_s && pop_s) begin
                        head_ld_s   = 1'b1;
                        state_nxt_s = ST_ONE;
                    end else if (acc_s) begin
                        skid_ld_s   = 1'b1;
                        state_nxt_s = ST_TWO;
                    end else if (pop_s) begin
                        head_clr_s  = 1'b1;
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (pop_s && skid_valid_s) begin
                        head_ld_s        = 1'b1;
                        head_from_skid_s = 1'b1;
                        skid_clr_s       = 1'b1;
                        state_nxt_s      = ST_ONE;
                    end else if (pop_s) begin
                        // Skid unexpectedly empty: recover to a clean EMPTY.
                        head_clr_s  = 1'b1;
                        state_nxt_s = ST_EMPTY;
                    end else begin
                        state_nxt_s = ST_TWO;
                    end
                end
                default: begin
                    head_clr_s  = 1'b1;
                    skid_clr_s  = 1'b1;
                    state_nxt_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Stage state, registered upstream ready and registered occupancy.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r    <= ST_EMPTY;
            in_ready_r <= 1'b1;
            occ_r      <= 2'd0;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= (state_nxt_s != ST_TWO);
            occ_r      <= state_occupancy(state_nxt_s);
        end
    end

    rr_exe_skid_stage_entry #(
        .ADDR_W (ADDR_W), .INST_W (INST_W), .CTRL_W (CTRL_W),
        .CAUSE_W(CAUSE_W), .SRC_W (SRC_W)
    ) u_head (
        .CLK       (CLK),
        .RST       (RST),
        .clr_i     (head_clr_s),
        .ld_i      (head_ld_s),
        .ld_pend_i (hld_pend_s),
        .ld_pc_i   (hld_pc_s),
        .ld_inst_i (hld_inst_s),
        .ld_ctrl_i (hld_ctrl_s),
        .ld_xcpt_i (hld_xcpt_s),
        .ld_cause_i(hld_cause_s),
        .ld_data_i (hld_data_s),
        .cap_i     (head_cap_s),
        .cap_data_i(src_data_i),
        .valid_o   (head_valid_s),
        .pend_o    (head_pend_s),
        .pc_o      (head_pc_s),
        .inst_o    (head_inst_s),
        .ctrl_o    (head_ctrl_s),
        .xcpt_o    (head_xcpt_s),
        .cause_o   (head_cause_s),
        .data_o    (head_data_s)
    );

    rr_exe_skid_stage_entry #(
        .ADDR_W (ADDR_W), .INST_W (INST_W), .CTRL_W (CTRL_W),
        .CAUSE_W(CAUSE_W), .SRC_W (SRC_W)
    ) u_skid (
        .CLK       (CLK),
        .RST       (RST),
        .clr_i     (skid_clr_s),
        .ld_i      (skid_ld_s),
        .ld_pend_i (inc_pend_s),
        .ld_pc_i   (in_pc_i),
        .ld_inst_i (in_inst_i),
        .ld_ctrl_i (inc_ctrl_s),
        .ld_xcpt_i (in_xcpt_i),
        .ld_cause_i(in_xcpt_cause_i),
        .ld_data_i (inc_data_s),
        .cap_i     (skid_cap_s),
        .cap_data_i(src_data_i),
        .valid_o   (skid_valid_s),
        .pend_o    (skid_pend_s),
        .pc_o      (skid_pc_s),
        .inst_o    (skid_inst_s),
        .ctrl_o    (skid_ctrl_s),
        .xcpt_o    (skid_xcpt_s),
        .cause_o   (skid_cause_s),
        .data_o    (skid_data_s)
    );

    assign in_ready_o       = in_ready_r;
    assign out_valid_o      = head_valid_s;
    assign out_pc_o         = head_pc_s;
    assign out_inst_o       = head_inst_s;
    assign out_ctrl_o       = head_ctrl_s;
    assign out_xcpt_o       = head_xcpt_s;
    assign out_xcpt_cause_o = head_cause_s;
    assign out_src_data_o   = head_pend_s ? src_data_i : head_data_s;
    assign occupancy_o      = occ_r;

endmodule

// File: tb/tb_rr_exe_skid_stage.sv
// Directed bench for rr_exe_skid_stage (default parameters, late operands).
module tb_rr_exe_skid_stage;

    logic          CLK;
    logic          RST;
    logic          flush_p1_i, flush_p2_i;
    logic          in_valid_i, in_ready_o;
    logic [39:0]   in_pc_i;
    logic [31:0]   in_inst_i;
    logic [15:0]   in_ctrl_i;
    logic          in_xcpt_i;
    logic [63:0]   in_xcpt_cause_i;
    logic [127:0]  src_data_i;
    logic          out_valid_o, out_ready_i;
    logic [39:0]   out_pc_o;
    logic [31:0]   out_inst_o;
    logic [15:0]   out_ctrl_o;
    logic          out_xcpt_o;
    logic [63:0]   out_xcpt_cause_o;
    logic [127:0]  out_src_data_o;
    logic [1:0]    occupancy_o;

    int n_cmp  = 0;
    int n_fail = 0;

    rr_exe_skid_stage dut (
        .CLK(CLK), .RST(RST),
        .flush_p1_i(flush_p1_i), .flush_p2_i(flush_p2_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_pc_i(in_pc_i), .in_inst_i(in_inst_i), .in_ctrl_i(in_ctrl_i),
        .in_xcpt_i(in_xcpt_i), .in_xcpt_cause_i(in_xcpt_cause_i),
        .src_data_i(src_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_pc_o(out_pc_o), .out_inst_o(out_inst_o), .out_ctrl_o(out_ctrl_o),
        .out_xcpt_o(out_xcpt_o), .out_xcpt_cause_o(out_xcpt_cause_o),
        .out_src_data_o(out_src_data_o), .occupancy_o(occupancy_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic beat(input logic [39:0] pc);
        in_valid_i      = 1'b1;
        in_pc_i         = pc;
        in_inst_i       = 32'h0000_0013;
        in_ctrl_i       = 16'h00A5;
        in_xcpt_i       = 1'b0;
        in_xcpt_cause_i = 64'd0;
    endtask

    initial begin
        RST = 1'b1;
        flush_p1_i = 1'b0; flush_p2_i = 1'b0;
        in_valid_i = 1'b0; in_pc_i = 40'd0; in_inst_i = 32'd0; in_ctrl_i = 16'd0;
        in_xcpt_i = 1'b0; in_xcpt_cause_i = 64'd0; src_data_i = 128'd0;
        out_ready_i = 1'b0;
        #2;
        chk("rst_in_ready",  128'(in_ready_o),  128'd1);
        chk("rst_out_valid", 128'(out_valid_o), 128'd0);
        chk("rst_occ",       128'(occupancy_o), 128'd0);
        chk("rst_out_pc",    128'(out_pc_o),    128'd0);
        #10;
        RST = 1'b0;

        // Stream at full rate
        out_ready_i = 1'b1;
        beat(40'h100); tick();
        chk("s_pc0",   128'(out_pc_o),   128'h100);
        chk("s_rdy0",  128'(in_ready_o), 128'd1);
        beat(40'h104); tick();
        chk("s_pc1",   128'(out_pc_o),   128'h104);
        beat(40'h108); tick();
        chk("s_pc2",   128'(out_pc_o),   128'h108);
        chk("s_occ2",  128'(occupancy_o), 128'd1);
        in_valid_i = 1'b0; tick();
        chk("s_drain_valid", 128'(out_valid_o), 128'd0);
        chk("s_drain_occ",   128'(occupancy_o), 128'd0);

        // Stall: three beats offered, two accepted
        out_ready_i = 1'b0;
        beat(40'h300); tick();
        chk("st_occ1", 128'(occupancy_o), 128'd1);
        beat(40'h304); tick();
        chk("st_occ2", 128'(occupancy_o), 128'd2);
        chk("st_rdy0", 128'(in_ready_o),  128'd0);
        beat(40'h308); tick();
        chk("st_hold_pc",  128'(out_pc_o),    128'h300);
        chk("st_hold_occ", 128'(occupancy_o), 128'd2);
        out_ready_i = 1'b1; tick();
        chk("st_rel_pc1", 128'(out_pc_o),   128'h304);
        chk("st_rel_rdy", 128'(in_ready_o), 128'd1);
        tick();
        chk("st_rel_pc2", 128'(out_pc_o),   128'h308);
        in_valid_i = 1'b0; tick();
        chk("st_empty", 128'(occupancy_o), 128'd0);

        // Late operands: bypass then stored value
        out_ready_i = 1'b0; src_data_i = 128'd0;
        beat(40'h400); tick();
        in_valid_i = 1'b0; src_data_i = 128'hAAAA; #1;
        chk("late_bypass", out_src_data_o, 128'hAAAA);
        tick();
        src_data_i = 128'h5555; #1;
        chk("late_stored", out_src_data_o, 128'hAAAA);
        out_ready_i = 1'b1; #1;
        chk("late_release", out_src_data_o, 128'hAAAA);
        tick();
        chk("late_popped", 128'(occupancy_o), 128'd0);

        // Flushes
        out_ready_i = 1'b0;
        beat(40'h200); tick();
        beat(40'h204); tick();
        in_valid_i = 1'b0; flush_p2_i = 1'b1; tick();
        flush_p2_i = 1'b0;
        chk("p2_occ",   128'(occupancy_o), 128'd1);
        chk("p2_pc",    128'(out_pc_o),    128'h200);
        chk("p2_valid", 128'(out_valid_o), 128'd1);
        chk("p2_rdy",   128'(in_ready_o),  128'd1);
        beat(40'h208); tick();
        chk("p1_pre_occ", 128'(occupancy_o), 128'd2);
        in_valid_i = 1'b0; flush_p1_i = 1'b1; tick();
        flush_p1_i = 1'b0;
        chk("p1_occ",   128'(occupancy_o), 128'd0);
        chk("p1_valid", 128'(out_valid_o), 128'd0);
        chk("p1_pc",    128'(out_pc_o),    128'd0);
        chk("p1_rdy",   128'(in_ready_o),  128'd1);
        beat(40'h20C); tick();
        in_valid_i = 1'b0; out_ready_i = 1'b1; flush_p2_i = 1'b1; tick();
        flush_p2_i = 1'b0;
        chk("p2_pop_occ", 128'(occupancy_o), 128'd0);

        // Exception beat
        out_ready_i = 1'b0;
        beat(40'h600); in_ctrl_i = 16'hFFFF; in_xcpt_i = 1'b1; in_xcpt_cause_i = 64'h2;
        tick();
        in_valid_i = 1'b0; in_xcpt_i = 1'b0; in_xcpt_cause_i = 64'd0;
        chk("x_xcpt",  128'(out_xcpt_o),       128'd1);
        chk("x_cause", 128'(out_xcpt_cause_o), 128'h2);
        chk("x_ctrl",  128'(out_ctrl_o),       128'h0);
        chk("x_pc",    128'(out_pc_o),         128'h600);
        out_ready_i = 1'b1; tick();
        chk("x_pop", 128'(out_valid_o), 128'd0);

        // Asynchronous reset while full
        out_ready_i = 1'b0;
        beat(40'h700); tick();
        beat(40'h704); tick();
        chk("r_pre_occ", 128'(occupancy_o), 128'd2);
        in_valid_i = 1'b0;
        #2 RST = 1'b1;
        #1;
        chk("r_valid", 128'(out_valid_o), 128'd0);
        chk("r_pc",    128'(out_pc_o),    128'd0);
        chk("r_rdy",   128'(in_ready_o),  128'd1);
        chk("r_occ",   128'(occupancy_o), 128'd0);
        #1 RST = 1'b0;
        tick();
        chk("r_post_occ", 128'(occupancy_o), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
